regfile_write_arbiter: RTL and testbench

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_pkg.sv | 23 ++
 rtl/regfile_write_arbiter_if.sv | 46 ++++
 rtl/regfile_write_arbiter.sv | 123 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the regfile write arbiter.
// Holds the burst FSM state encoding and the regfile word map.
package regfile_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W1   = 2'd1,
    W2   = 2'd2,
    W3   = 2'd3
  } state_t;

  localparam int REG_COUNT        = 113;
  localparam int DONE_ADDR        = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  localparam logic [7:0] REG_CTRL   = 8'd0;
  localparam logic [7:0] REG_STATUS = 8'd1;
  localparam logic [7:0] REG_DONE   = 8'(DONE_ADDR);

  localparam logic [3:0] BE_FULL = 4'b1111;
  localparam logic [3:0] BE_DONE = 4'b0001;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Host (Avalon-MM), physics-FSM burst and regfile write-port signals.
// The arbiter sits on the slave modport; host, FSM and regfile sit on master.
interface regfile_write_arbiter_if;

  logic        AVL_CS;
  logic        AVL_WRITE;
  logic [3:0]  AVL_BYTE_EN;
  logic [7:0]  AVL_ADDR;
  logic [31:0] AVL_WRITEDATA;
  logic        AVL_WAITREQUEST;

  logic        FSM_REQ;
  logic [7:0]  FSM_ADDR1;
  logic [7:0]  FSM_ADDR2;
  logic [7:0]  FSM_ADDR3;
  logic [31:0] FSM_DATA1;
  logic [31:0] FSM_DATA2;
  logic [31:0] FSM_DATA3;
  logic        FSM_ACK;
  logic        FSM_DONE;

  logic        WR_EN;
  logic [7:0]  WR_ADDR;
  logic [3:0]  WR_BE;
  logic [31:0] WR_DATA;
  logic        ADDR_ERR;

  modport slave (
    input  AVL_CS, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_WAITREQUEST,
    input  FSM_REQ, FSM_ADDR1, FSM_ADDR2, FSM_ADDR3,
    input  FSM_DATA1, FSM_DATA2, FSM_DATA3, FSM_DONE,
    output FSM_ACK,
    output WR_EN, WR_ADDR, WR_BE, WR_DATA, ADDR_ERR
  );

  modport master (
    output AVL_CS, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_WAITREQUEST,
    output FSM_REQ, FSM_ADDR1, FSM_ADDR2, FSM_ADDR3,
    output FSM_DATA1, FSM_DATA2, FSM_DATA3, FSM_DONE,
    input  FSM_ACK,
    input  WR_EN, WR_ADDR, WR_BE, WR_DATA, ADDR_ERR
  );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Single regfile write port shared by host writes, a 3-word FSM burst and DONE-flag updates.
// One cycle to WR_*; host stalled via AVL_WAITREQUEST once the FSM has been starved STARVE_LIMIT times.
module regfile_write_arbiter #(
  parameter int REG_COUNT    = regfile_write_arbiter_pkg::REG_COUNT,
  parameter int STARVE_LIMIT = regfile_write_arbiter_pkg::STARVE_LIMIT_DEF,
  parameter int DONE_ADDR    = regfile_write_arbiter_pkg::DONE_ADDR
) (
  input  logic                  CLK,
  input  logic                  RESET,
  regfile_write_arbiter_if.slave bus
);

  import regfile_write_arbiter_pkg::*;

  localparam int              SW         = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [8:0]      ADDR_LIM   = 9'(REG_COUNT);
  localparam logic [7:0]      DONE_WORD  = 8'(DONE_ADDR);

  state_t           state_q, state_d;
  logic [2:0][7:0]  cap_addr_q;
  logic [2:0][31:0] cap_data_q;
  logic [SW-1:0]    starve_q;
  logic             done_pend_q;
  logic             done_last_q;

  logic        host_acc, capture, fsm_issue, done_issue, burst_end, pending;
  logic        sel_vld, sel_ok;
  logic [7:0]  sel_addr;
  logic [3:0]  sel_be;
  logic [31:0] sel_data;

  assign bus.AVL_WAITREQUEST = ~RESET & (starve_q == STARVE_MAX) &
                               ((state_q != IDLE) | bus.FSM_REQ);

  always_comb begin
    host_acc   = bus.AVL_CS & bus.AVL_WRITE & ~bus.AVL_WAITREQUEST & ~RESET;
    // The ACK cycle still sees the old request held high; don't re-capture it.
    capture    = (state_q == IDLE) & bus.FSM_REQ & ~bus.FSM_ACK;
    fsm_issue  = (state_q != IDLE) & ~host_acc;
    done_issue = done_pend_q & ~host_acc & ~fsm_issue;
    burst_end  = (state_q == W3) & fsm_issue;
    pending    = (state_q != IDLE) | capture;

    sel_vld  = 1'b0;
    sel_addr = bus.AVL_ADDR;
    sel_be   = bus.AVL_BYTE_EN;
    sel_data = bus.AVL_WRITEDATA;
    if (host_acc) begin
      sel_vld = 1'b1;
    end else if (fsm_issue) begin
      sel_vld = 1'b1;
      sel_be  = BE_FULL;
      case (state_q)
        W1:      begin sel_addr = cap_addr_q[0]; sel_data = cap_data_q[0]; end
        W2:      begin sel_addr = cap_addr_q[1]; sel_data = cap_data_q[1]; end
        default: begin sel_addr = cap_addr_q[2]; sel_data = cap_data_q[2]; end
      endcase
    end else if (done_issue) begin
      sel_vld  = 1'b1;
      sel_addr = DONE_WORD;
      sel_be   = BE_DONE;
      sel_data = {31'b0, bus.FSM_DONE};
    end
    sel_ok = ({1'b0, sel_addr} < ADDR_LIM);

    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)   state_d = W1;
      W1:      if (fsm_issue) state_d = W2;
      W2:      if (fsm_issue) state_d = W3;
      default: if (fsm_issue) state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      starve_q     <= '0;
      done_pend_q  <= 1'b0;
      done_last_q  <= 1'b0;
      bus.WR_EN    <= 1'b0;
      bus.WR_ADDR  <= '0;
      bus.WR_BE    <= '0;
      bus.WR_DATA  <= '0;
      bus.FSM_ACK  <= 1'b0;
      bus.ADDR_ERR <= 1'b0;
    end else begin
      if (capture) begin
        cap_addr_q <= {bus.FSM_ADDR3, bus.FSM_ADDR2, bus.FSM_ADDR1};
        cap_data_q <= {bus.FSM_DATA3, bus.FSM_DATA2, bus.FSM_DATA1};
      end

      // Out-of-range writes burn their slot but never reach the regfile.
      bus.WR_EN <= sel_vld & sel_ok;
      if (sel_vld & sel_ok) begin
        bus.WR_ADDR <= sel_addr;
        bus.WR_BE   <= sel_be;
        bus.WR_DATA <= sel_data;
      end
      if (sel_vld & ~sel_ok) bus.ADDR_ERR <= 1'b1;

      bus.FSM_ACK <= burst_end;

      if (burst_end)
        starve_q <= '0;
      else if (pending & host_acc & (starve_q != STARVE_MAX))
        starve_q <= starve_q + SW'(1);

      if (done_issue) begin
        done_last_q <= bus.FSM_DONE;
        done_pend_q <= 1'b0;
      end else if (bus.FSM_DONE != done_last_q) begin
        done_pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: host path, FSM burst, starvation stall,
// DONE update, address error and reset mid-burst.
module tb_regfile_write_arbiter;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter #(
    .REG_COUNT   (113),
    .STARVE_LIMIT(4),
    .DONE_ADDR   (2)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic host(input logic [7:0] a, input logic [31:0] d);
    bus.AVL_CS        = 1'b1;
    bus.AVL_WRITE     = 1'b1;
    bus.AVL_BYTE_EN   = 4'hF;
    bus.AVL_ADDR      = a;
    bus.AVL_WRITEDATA = d;
  endtask

  task automatic host_off();
    bus.AVL_CS    = 1'b0;
    bus.AVL_WRITE = 1'b0;
  endtask

  task automatic fsm_req(input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] a3,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    bus.FSM_ADDR1 = a1; bus.FSM_ADDR2 = a2; bus.FSM_ADDR3 = a3;
    bus.FSM_DATA1 = d1; bus.FSM_DATA2 = d2; bus.FSM_DATA3 = d3;
    bus.FSM_REQ   = 1'b1;
  endtask

  task automatic chk_wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be);
    chk({tag, "_en"},   32'(bus.WR_EN),   32'd1);
    chk({tag, "_addr"}, 32'(bus.WR_ADDR), 32'(a));
    chk({tag, "_data"}, bus.WR_DATA,      d);
    chk({tag, "_be"},   32'(bus.WR_BE),   32'(be));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    RESET = 1'b1;
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_BYTE_EN = 4'h0;
    bus.AVL_ADDR = 8'h0; bus.AVL_WRITEDATA = 32'h0;
    bus.FSM_REQ = 1'b0; bus.FSM_DONE = 1'b0;
    bus.FSM_ADDR1 = 8'h0; bus.FSM_ADDR2 = 8'h0; bus.FSM_ADDR3 = 8'h0;
    bus.FSM_DATA1 = 32'h0; bus.FSM_DATA2 = 32'h0; bus.FSM_DATA3 = 32'h0;

    // Reset: outputs zero, host write ignored, no waitrequest
    step; step;
    host(8'd5, 32'h55);
    #1 chk("rst_waitreq", 32'(bus.AVL_WAITREQUEST), 32'd0);
    step;
    chk("rst_wr_en",    32'(bus.WR_EN),    32'd0);
    chk("rst_wr_addr",  32'(bus.WR_ADDR),  32'd0);
    chk("rst_wr_be",    32'(bus.WR_BE),    32'd0);
    chk("rst_wr_data",  bus.WR_DATA,       32'd0);
    chk("rst_ack",      32'(bus.FSM_ACK),  32'd0);
    chk("rst_addr_err", 32'(bus.ADDR_ERR), 32'd0);
    host_off;
    RESET = 1'b0;
    step;

    // Single host write
    host(8'd12, 32'h0000_0040);
    step;
    host_off;
    chk_wr("host12", 8'd12, 32'h40, 4'hF);
    step;
    chk("host_idle_en",   32'(bus.WR_EN),   32'd0);
    chk("host_idle_hold", 32'(bus.WR_ADDR), 32'd12);

    // Uncontended FSM burst
    fsm_req(8'd23, 8'd33, 8'd43, 32'd1, 32'd2, 32'd3);
    step;
    chk("burst_cap_en", 32'(bus.WR_EN), 32'd0);
    step;
    chk_wr("burst_w1", 8'd23, 32'd1, 4'hF);
    chk("burst_w1_ack", 32'(bus.FSM_ACK), 32'd0);
    step;
    chk_wr("burst_w2", 8'd33, 32'd2, 4'hF);
    chk("burst_w2_ack", 32'(bus.FSM_ACK), 32'd0);
    step;
    chk_wr("burst_w3", 8'd43, 32'd3, 4'hF);
    chk("burst_w3_ack", 32'(bus.FSM_ACK), 32'd1);
    bus.FSM_REQ = 1'b0;
    step;
    chk("burst_after_ack", 32'(bus.FSM_ACK), 32'd0);
    chk("burst_after_en",  32'(bus.WR_EN),   32'd0);

    // Starvation: four host wins, then stall while the burst drains
    fsm_req(8'd60, 8'd61, 8'd62, 32'h11, 32'h12, 32'h13);
    for (int i = 0; i < 4; i++) begin
      host(8'(50 + i), 32'(i));
      #1 chk("starve_wait_lo", 32'(bus.AVL_WAITREQUEST), 32'd0);
      step;
      chk_wr("starve_host", 8'(50 + i), 32'(i), 4'hF);
    end
    host(8'd54, 32'd4);
    for (int j = 0; j < 3; j++) begin
      chk("starve_wait_hi", 32'(bus.AVL_WAITREQUEST), 32'd1);
      step;
      chk_wr("starve_fsm", 8'(60 + j), 32'(32'h11 + j), 4'hF);
      chk("starve_ack", 32'(bus.FSM_ACK), (j == 2) ? 32'd1 : 32'd0);
    end
    bus.FSM_REQ = 1'b0;
    #1 chk("starve_wait_drop", 32'(bus.AVL_WAITREQUEST), 32'd0);
    step;
    chk_wr("starve_host_resume", 8'd54, 32'd4, 4'hF);
    host_off;
    step;

    // DONE rising during a burst: written once, right after word 3
    fsm_req(8'd70, 8'd71, 8'd72, 32'd7, 32'd8, 32'd9);
    step;
    bus.FSM_DONE = 1'b1;
    step;
    chk_wr("done_w1", 8'd70, 32'd7, 4'hF);
    step;
    chk_wr("done_w2", 8'd71, 32'd8, 4'hF);
    step;
    chk_wr("done_w3", 8'd72, 32'd9, 4'hF);
    chk("done_w3_ack", 32'(bus.FSM_ACK), 32'd1);
    bus.FSM_REQ = 1'b0;
    step;
    chk_wr("done_wr", 8'd2, 32'd1, 4'h1);
    step;
    chk("done_nodup1", 32'(bus.WR_EN), 32'd0);
    step;
    chk("done_nodup2", 32'(bus.WR_EN), 32'd0);

    // Out-of-range host write: dropped, sticky error
    host(8'd200, 32'hDEAD);
    step;
    host_off;
    chk("oor_en",  32'(bus.WR_EN),    32'd0);
    chk("oor_err", 32'(bus.ADDR_ERR), 32'd1);
    step; step;
    chk("oor_err_sticky", 32'(bus.ADDR_ERR), 32'd1);
    host(8'd13, 32'h77);
    step;
    host_off;
    chk_wr("oor_next", 8'd13, 32'h77, 4'hF);
    chk("oor_err_still", 32'(bus.ADDR_ERR), 32'd1);

    // Reset in W2, burst restarts from word 1 afterwards
    fsm_req(8'd80, 8'd81, 8'd82, 32'hA, 32'hB, 32'hC);
    step;
    step;
    chk_wr("rw2_w1", 8'd80, 32'hA, 4'hF);
    RESET = 1'b1;
    step;
    chk("rw2_rst_ack", 32'(bus.FSM_ACK),  32'd0);
    chk("rw2_rst_en",  32'(bus.WR_EN),    32'd0);
    chk("rw2_rst_err", 32'(bus.ADDR_ERR), 32'd0);
    chk("rw2_rst_wait", 32'(bus.AVL_WAITREQUEST), 32'd0);
    RESET = 1'b0;
    step;
    chk("rw2_cap_en",  32'(bus.WR_EN),   32'd0);
    chk("rw2_cap_ack", 32'(bus.FSM_ACK), 32'd0);
    step;
    chk_wr("rw2_r1", 8'd80, 32'hA, 4'hF);
    step;
    chk_wr("rw2_r2", 8'd81, 32'hB, 4'hF);
    step;
    chk_wr("rw2_r3", 8'd82, 32'hC, 4'hF);
    chk("rw2_r3_ack", 32'(bus.FSM_ACK), 32'd1);
    bus.FSM_REQ = 1'b0;
    step;
    chk_wr("rw2_done", 8'd2, 32'd1, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
